id_ex_reg: RTL

ID/EX pipeline register of the five-stage CPU. It captures decoded operands, the immediate and control from ID and presents them to EX. The EX operand muxes take the 32-bit data0/data1 candidates (rt data vs. sign-extended immediate) and the select (alusrc) directly from this block. It supports stall (hold), flush (bubble insertion) and write-back refresh of held operands, so a stalled instruction never consumes stale register data.

---
 rtl/id_ex_reg.sv | 99 +++++++++
 1 files changed

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_reg
//  Description : ID/EX pipeline register. Captures decoded operands, the
//                immediate and control from ID and presents them to EX.
//                Supports stall (hold), flush (bubble) and write-back
//                refresh of held source operands while stalled.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_reg #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int AOPW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [DW-1:0]   id_pc,
  input  logic [DW-1:0]   id_rs_data,
  input  logic [DW-1:0]   id_rt_data,
  input  logic [DW-1:0]   id_imm,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic [RW-1:0]   id_rd,
  input  logic [AOPW-1:0] id_alu_op,
  input  logic            id_alusrc,
  input  logic            id_regwrite,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_addr,
  input  logic [DW-1:0]   wb_data,
  output logic            ex_valid,
  output logic [DW-1:0]   ex_pc,
  output logic [DW-1:0]   ex_rs_data,
  output logic [DW-1:0]   ex_rt_data,
  output logic [DW-1:0]   ex_imm,
  output logic [RW-1:0]   ex_rs,
  output logic [RW-1:0]   ex_rt,
  output logic [RW-1:0]   ex_rd,
  output logic [AOPW-1:0] ex_alu_op,
  output logic            ex_alusrc,
  output logic            ex_regwrite,
  output logic            ex_memwrite,
  output logic            ex_memtoreg
);

  // A write-back to a non-zero register that a held instruction reads
  // must replace the stale operand; register 0 is hard-wired to zero.
  logic wb_live;
  logic rs_refresh;
  logic rt_refresh;

  assign wb_live    = wb_we && (wb_addr != '0);
  assign rs_refresh = wb_live && (wb_addr == ex_rs);
  assign rt_refresh = wb_live && (wb_addr == ex_rt);

  // Pipeline register: reset and flush both produce an all-zero bubble,
  // stall holds (with operand refresh), otherwise load from ID.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_alu_op   <= '0;
      ex_alusrc   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
    end else if (stall) begin
      if (rs_refresh) ex_rs_data <= wb_data;
      if (rt_refresh) ex_rt_data <= wb_data;
    end else begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
      ex_alu_op   <= id_alu_op;
      ex_alusrc   <= id_alusrc;
      // Side-effecting control is suppressed for a non-instruction.
      ex_regwrite <= id_valid & id_regwrite;
      ex_memwrite <= id_valid & id_memwrite;
      ex_memtoreg <= id_valid & id_memtoreg;
    end
  end

endmodule
`default_nettype wire
